dense_layer1_16: RTL and testbench

DENSE_LAYER1_16 -- requirements
Module: dense_layer1_16

---
 rtl/dense_layer1_16.sv | 154 +++++++++++++++
 tb/tb_dense_layer1_16.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_layer1_16.sv
// Fully connected layer in signed fixed point, evaluated one multiply per clock.
// Each neuron takes IN_SIZE MAC cycles followed by one bias/shift/saturate/ReLU cycle.
// All operands are captured at start, so the input ports may change freely while the layer is busy.
module dense_layer1_16 #(
    parameter int IN_SIZE   = 1,
    parameter int OUT_SIZE  = 8,
    parameter int W         = 8,
    parameter int FRAC_BITS = 4,
    parameter int ACC_W     = 24,
    parameter int RELU      = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [IN_SIZE*W-1:0]         data_in,
    input  logic [IN_SIZE*OUT_SIZE*W-1:0] weights_in,
    input  logic [OUT_SIZE*W-1:0]        bias_in,
    output logic [OUT_SIZE*W-1:0]        data_out,
    output logic                         busy,
    output logic                         done
);

    localparam int KW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int NW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (W - 1)));

    typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} state_t;

    state_t state_reg, state_next;

    logic [IN_SIZE*W-1:0]          x_reg;
    logic [IN_SIZE*OUT_SIZE*W-1:0] w_reg;
    logic [OUT_SIZE*W-1:0]         b_reg;
    logic signed [ACC_W-1:0]       acc_reg;
    logic [KW-1:0]                 k_reg;
    logic [NW-1:0]                 n_reg;

    logic signed [W-1:0] x_arr   [IN_SIZE];
    logic signed [W-1:0] w_arr   [IN_SIZE*OUT_SIZE];
    logic signed [W-1:0] b_arr   [OUT_SIZE];
    logic signed [W-1:0] out_arr [OUT_SIZE];

    logic signed [W-1:0]     x_sel, w_sel, b_sel;
    logic signed [2*W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext, acc_mac;
    logic signed [ACC_W-1:0] bias_ext, pre_shift, shifted;
    logic signed [W-1:0]     act_res;
    logic                    last_k, last_n, capture;

    // Unpack captured operand vectors and repack the result registers.
    genvar gi;
    generate
        for (gi = 0; gi < IN_SIZE; gi++) begin : g_x
            assign x_arr[gi] = x_reg[gi*W +: W];
        end
        for (gi = 0; gi < IN_SIZE*OUT_SIZE; gi++) begin : g_w
            assign w_arr[gi] = w_reg[gi*W +: W];
        end
        for (gi = 0; gi < OUT_SIZE; gi++) begin : g_b
            assign b_arr[gi]          = b_reg[gi*W +: W];
            assign data_out[gi*W +: W] = out_arr[gi];
        end
    endgenerate

    assign last_k  = (int'(k_reg) == IN_SIZE - 1);
    assign last_n  = (int'(n_reg) == OUT_SIZE - 1);
    assign capture = start && (state_reg == IDLE || state_reg == DONE);
    assign busy    = (state_reg == MAC) || (state_reg == ACT);
    assign done    = (state_reg == DONE);

    // Operand selection for the current (neuron, input) pair.
    always_comb begin
        x_sel = '0;
        w_sel = '0;
        b_sel = '0;
        for (int i = 0; i < IN_SIZE; i++)
            if (int'(k_reg) == i) x_sel = x_arr[i];
        for (int i = 0; i < IN_SIZE*OUT_SIZE; i++)
            if (int'(n_reg) * IN_SIZE + int'(k_reg) == i) w_sel = w_arr[i];
        for (int i = 0; i < OUT_SIZE; i++)
            if (int'(n_reg) == i) b_sel = b_arr[i];
    end

    // Full-width product, accumulation, and the activation stage.
    always_comb begin
        prod      = x_sel * w_sel;
        prod_ext  = {{(ACC_W-2*W){prod[2*W-1]}}, prod};
        acc_mac   = acc_reg + prod_ext;
        bias_ext  = {{(ACC_W-W){b_sel[W-1]}}, b_sel};
        pre_shift = acc_reg + (bias_ext <<< FRAC_BITS);
        shifted   = pre_shift >>> FRAC_BITS;
        if (shifted > SAT_MAX)
            act_res = {1'b0, {(W-1){1'b1}}};
        else if (shifted < SAT_MIN)
            act_res = {1'b1, {(W-1){1'b0}}};
        else
            act_res = shifted[W-1:0];
        if (RELU != 0 && act_res[W-1])
            act_res = '0;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: if (start) state_next = MAC;
            MAC:        if (last_k) state_next = ACT;
            ACT:        state_next = last_n ? DONE : MAC;
            default:    state_next = IDLE;
        endcase
    end

    // Operand capture, MAC accumulation, index stepping and result write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg   <= '0;
            w_reg   <= '0;
            b_reg   <= '0;
            acc_reg <= '0;
            k_reg   <= '0;
            n_reg   <= '0;
            for (int i = 0; i < OUT_SIZE; i++)
                out_arr[i] <= '0;
        end else begin
            if (capture) begin
                x_reg   <= data_in;
                w_reg   <= weights_in;
                b_reg   <= bias_in;
                acc_reg <= '0;
                k_reg   <= '0;
                n_reg   <= '0;
            end else if (state_reg == MAC) begin
                acc_reg <= acc_mac;
                k_reg   <= k_reg + KW'(1);
            end else if (state_reg == ACT) begin
                for (int i = 0; i < OUT_SIZE; i++)
                    if (int'(n_reg) == i) out_arr[i] <= act_res;
                acc_reg <= '0;
                k_reg   <= '0;
                if (!last_n) n_reg <= n_reg + NW'(1);
            end
        end
    end

endmodule

// File: tb/tb_dense_layer1_16.sv
// Randomized and directed bench for dense_layer1_16: three instances (defaults,
// RELU=0, IN_SIZE=3) run in lockstep against an integer reference of the layer math.
module tb_dense_layer1_16;

    localparam int W   = 8;
    localparam int OUT = 8;
    localparam int IN2 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    int x0 [1];
    int w0 [OUT];
    int b0 [OUT];
    int x2 [IN2];
    int w2 [OUT*IN2];
    int b2 [OUT];
    int e0 [OUT];
    int e1 [OUT];
    int e2 [OUT];

    logic [W-1:0]         d0_v;
    logic [OUT*W-1:0]     w0_v, b0_v, b2_v;
    logic [IN2*W-1:0]     d2_v;
    logic [OUT*IN2*W-1:0] w2_v;
    logic [OUT*W-1:0]     q0, q1, q2;
    logic busy0, busy1, busy2, done0, done1, done2;

    int checks = 0;
    int failures = 0;

    always_comb begin
        d0_v = W'(x0[0]);
        w0_v = '0;
        b0_v = '0;
        d2_v = '0;
        w2_v = '0;
        b2_v = '0;
        for (int i = 0; i < OUT; i++) begin
            w0_v[i*W +: W] = W'(w0[i]);
            b0_v[i*W +: W] = W'(b0[i]);
            b2_v[i*W +: W] = W'(b2[i]);
        end
        for (int i = 0; i < IN2; i++)
            d2_v[i*W +: W] = W'(x2[i]);
        for (int i = 0; i < OUT*IN2; i++)
            w2_v[i*W +: W] = W'(w2[i]);
    end

    dense_layer1_16 dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in(d0_v), .weights_in(w0_v),
        .bias_in(b0_v), .data_out(q0), .busy(busy0), .done(done0));

    dense_layer1_16 #(.RELU(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in(d0_v), .weights_in(w0_v),
        .bias_in(b0_v), .data_out(q1), .busy(busy1), .done(done1));

    dense_layer1_16 #(.IN_SIZE(IN2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in(d2_v), .weights_in(w2_v),
        .bias_in(b2_v), .data_out(q2), .busy(busy2), .done(done2));

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int elem(input logic [OUT*W-1:0] v, input int n);
        logic signed [W-1:0] t;
        t = v[n*W +: W];
        return int'(t);
    endfunction

    // Dot product plus bias in Q.FRAC, floor-divided back to integer scale, clamped.
    function automatic int neuron_ref(input int xs[$], input int ws[$], input int b, input bit relu);
        int sum, q;
        sum = b * 16;
        foreach (xs[i]) sum += xs[i] * ws[i];
        q = sum / 16;
        if (sum < 0 && (sum % 16) != 0) q -= 1;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        if (relu && q < 0) q = 0;
        return q;
    endfunction

    function automatic int rnd();
        return int'($urandom_range(255)) - 128;
    endfunction

    task automatic compute_exp(input bit do2);
        int xs[$];
        int ws[$];
        for (int n = 0; n < OUT; n++) begin
            xs = {};
            ws = {};
            xs.push_back(x0[0]);
            ws.push_back(w0[n]);
            e0[n] = neuron_ref(xs, ws, b0[n], 1'b1);
            e1[n] = neuron_ref(xs, ws, b0[n], 1'b0);
            if (do2) begin
                xs = {};
                ws = {};
                for (int k = 0; k < IN2; k++) begin
                    xs.push_back(x2[k]);
                    ws.push_back(w2[n*IN2+k]);
                end
                e2[n] = neuron_ref(xs, ws, b2[n], 1'b1);
            end
        end
    endtask

    task automatic fill(input int xv, input int wv, input int bv);
        x0[0] = xv;
        for (int i = 0; i < OUT; i++) begin
            w0[i] = wv;
            b0[i] = bv;
            b2[i] = bv;
        end
        for (int i = 0; i < IN2; i++) x2[i] = xv;
        for (int i = 0; i < OUT*IN2; i++) w2[i] = wv;
    endtask

    task automatic randomize_inputs();
        x0[0] = rnd();
        for (int i = 0; i < OUT; i++) begin
            w0[i] = rnd();
            b0[i] = rnd();
            b2[i] = rnd();
        end
        for (int i = 0; i < IN2; i++) x2[i] = rnd();
        for (int i = 0; i < OUT*IN2; i++) w2[i] = rnd();
    endtask

    task automatic check_all(input string tag, input bit do2);
        for (int n = 0; n < OUT; n++) begin
            chk($sformatf("%s_d0_e%0d", tag, n), elem(q0, n), e0[n]);
            chk($sformatf("%s_d1_e%0d", tag, n), elem(q1, n), e1[n]);
            if (do2) chk($sformatf("%s_d2_e%0d", tag, n), elem(q2, n), e2[n]);
        end
        $display("TXN %s checks=%0d failures=%0d", tag, checks, failures);
    endtask

    // Pulse start for one edge; returns 1 time unit after the capture edge.
    task automatic kick();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Called just after a capture edge: measure done latency of every instance.
    task automatic finish_eval(input string tag);
        int l0, l1, l2;
        l0 = -1; l1 = -1; l2 = -1;
        chk({tag, "_busy"}, int'(busy0), 1);
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (done0 && l0 < 0) l0 = c;
            if (done1 && l1 < 0) l1 = c;
            if (done2 && l2 < 0) l2 = c;
            if (l0 >= 0 && l1 >= 0 && l2 >= 0) break;
        end
        chk({tag, "_lat0"}, l0, 16);
        chk({tag, "_lat1"}, l1, 16);
        chk({tag, "_lat2"}, l2, 32);
        check_all(tag, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with start held high: nothing happens until the first edge after release.
        fill(16, 16, 0);
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_q0_zero", int'(q0 != '0), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        compute_exp(1'b1);
        finish_eval("basic16");
        chk("basic16_lit_e0", elem(q0, 0), 16);
        chk("basic16_lit_d2_e7", elem(q2, 7), 48);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_done", int'(done0), 1);
        chk("hold_e3", elem(q0, 3), 16);

        fill(127, 127, 127);
        compute_exp(1'b1);
        kick();
        finish_eval("satpos");
        chk("satpos_lit", elem(q1, 0), 127);

        fill(-128, 127, 0);
        compute_exp(1'b1);
        kick();
        finish_eval("satneg");
        chk("satneg_lit_relu0", elem(q1, 4), -128);
        chk("satneg_lit_relu1", elem(q0, 4), 0);

        fill(16, -32, 0);
        compute_exp(1'b1);
        kick();
        finish_eval("relu");
        chk("relu_lit_relu1", elem(q0, 0), 0);
        chk("relu_lit_relu0", elem(q1, 0), -32);

        fill(0, 16, 0);
        for (int n = 0; n < OUT; n++) begin
            b0[n] = n + 1;
            b2[n] = n + 1;
        end
        for (int k = 0; k < IN2; k++) x2[k] = 16;
        w2[0] = 16; w2[1] = 32; w2[2] = -16;
        compute_exp(1'b1);
        kick();
        finish_eval("bias");
        chk("bias_lit_e5", elem(q0, 5), 6);
        chk("bias_lit_d2_e0", elem(q2, 0), 33);

        for (int t = 0; t < 12; t++) begin
            randomize_inputs();
            compute_exp(1'b1);
            kick();
            finish_eval($sformatf("rand%0d", t));
        end

        // Abort during the fifth MAC cycle.
        fill(16, 16, 0);
        compute_exp(1'b1);
        kick();
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_q0_zero", int'(q0 != '0), 0);
        chk("midrst_q2_zero", int'(q2 != '0), 0);
        chk("midrst_busy", int'(busy0), 0);
        chk("midrst_done", int'(done0), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_idle", int'(busy0), 0);
        kick();
        finish_eval("after_rst");

        // Start held high through an evaluation; inputs change right after capture.
        begin
            int l0;
            randomize_inputs();
            compute_exp(1'b1);
            @(negedge clk) start = 1'b1;
            @(posedge clk);
            #1;
            randomize_inputs();
            for (int c = 1; c <= 16; c++) begin
                @(posedge clk);
                #1;
                if (c == 15) chk("held_pre_done", int'(done0), 0);
            end
            chk("held_done16", int'(done0), 1);
            check_all("held_A", 1'b0);
            @(posedge clk);
            #1;
            chk("held_recap_busy", int'(busy0), 1);
            chk("held_recap_done", int'(done0), 0);
            start = 1'b0;
            compute_exp(1'b0);
            l0 = -1;
            for (int c = 1; c <= 60; c++) begin
                if (done0 && l0 < 0) l0 = c;
                if (done0 && done1 && done2) break;
                @(posedge clk);
                #1;
            end
            chk("held_B_lat_ok", int'(l0 > 0 && l0 <= 17), 1);
            check_all("held_B", 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
